// File: rtl/demux_deser_pkg.sv
// demux_deser_pkg: shared FSM state type and bit-position helpers for the deserializer.
package demux_deser_pkg;
  typedef enum logic {COLLECT, LAST} state_t;
  function automatic int sel_w(input int width);
    return $clog2(width);
  endfunction
  function automatic int start_pos(input int width, input bit msb_first);
    return msb_first ? width - 1 : 0;
  endfunction
  function automatic int end_pos(input int width, input bit msb_first);
    return msb_first ? 0 : width - 1;
  endfunction
endpackage

// File: rtl/demux_deser_outreg.sv
// demux_deser_outreg: word holding register with valid/ready, load-while-pop and sticky overrun.
module demux_deser_outreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, overrun_q, overrun_d, drop, take;
  always_comb begin
    drop      = load_i && valid_q && !ready_i;
    take      = load_i && !drop;
    data_d    = take ? data_i : data_q;
    valid_d   = take || (valid_q && !ready_i);
    overrun_d = overrun_q || drop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
endmodule

// File: rtl/demux_deser8.sv
// demux_deser8: serial-to-parallel deserializer; a registered 1:WIDTH demux select steers each bit into the word.
module demux_deser8
  import demux_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    sync,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [sel_w(WIDTH)-1:0] sel,
  output logic                    overrun
);
  localparam int SEL_W = sel_w(WIDTH);
  localparam logic [SEL_W-1:0] START = SEL_W'(start_pos(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] FINAL = SEL_W'(end_pos(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] STEP = MSB_FIRST ? '1 : SEL_W'(1);
  localparam logic [SEL_W-1:0] AFTER_START = START + STEP;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_inc;
  logic [WIDTH-1:0] asm_q, asm_d, word;
  logic complete;
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    asm_d    = asm_q;
    complete = 1'b0;
    sel_inc  = sel_q + STEP;
    word     = asm_q;
    word[sel_q] = din;
    if (sync) begin
      asm_d        = '0;
      asm_d[START] = din_valid && din;
      sel_d        = din_valid ? AFTER_START : START;
      state_d      = (din_valid && AFTER_START == FINAL) ? LAST : COLLECT;
    end else if (din_valid) begin
      complete = state_q == LAST;
      asm_d    = complete ? '0 : word;
      sel_d    = complete ? START : sel_inc;
      state_d  = (!complete && sel_inc == FINAL) ? LAST : COLLECT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      sel_q   <= START;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      asm_q   <= asm_d;
    end
  end
  assign sel = sel_q;
  demux_deser_outreg #(.WIDTH(WIDTH)) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (complete),
    .data_i   (word),
    .ready_i  (dout_ready),
    .data_o   (dout),
    .valid_o  (dout_valid),
    .overrun_o(overrun)
  );
endmodule

// File: tb/tb_demux_deser8.sv
// tb_demux_deser8: scoreboard bench for LSB-first and MSB-first deserializer instances.
module tb_demux_deser8;
  logic clk = 1'b0, rst = 1'b1;
  logic din = 1'b0, din_valid = 1'b0, sync = 1'b0, dout_ready = 1'b1;
  logic [7:0] dout;
  logic dout_valid, overrun;
  logic [2:0] sel;
  logic m_din = 1'b0, m_vld = 1'b0;
  logic [7:0] m_dout;
  logic m_valid_o, m_ovr_o;
  logic [2:0] m_sel;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] ref_asm = '0;
  int ref_cnt = 0;
  bit ref_valid = 1'b0, ref_ovr = 1'b0;

  demux_deser8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .sel(sel), .overrun(overrun)
  );
  demux_deser8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(m_din), .din_valid(m_vld), .sync(1'b0),
    .dout(m_dout), .dout_valid(m_valid_o), .dout_ready(1'b1), .sel(m_sel), .overrun(m_ovr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (q.size() == 0) chk("sb_unexpected_word", 32'(dout), 32'hxxxx_xxxx);
      else chk("sb_word", 32'(dout), 32'(q.pop_front()));
    end
  end

  task automatic model_clear();
    ref_asm = '0; ref_cnt = 0; ref_valid = 1'b0; ref_ovr = 1'b0;
    q.delete();
  endtask

  task automatic send(input logic b, input logic v, input logic s);
    logic [7:0] w;
    bit load;
    din = b; din_valid = v; sync = s;
    load = 1'b0;
    w = '0;
    if (s) begin
      ref_asm = '0;
      ref_asm[0] = v && b;
      ref_cnt = v ? 1 : 0;
    end else if (v) begin
      ref_asm[ref_cnt] = b;
      if (ref_cnt == 7) begin
        load = 1'b1; w = ref_asm; ref_asm = '0; ref_cnt = 0;
      end else ref_cnt++;
    end
    if (load) begin
      if (ref_valid && !dout_ready) ref_ovr = 1'b1;
      else begin q.push_back(w); ref_valid = 1'b1; end
    end else if (dout_ready) ref_valid = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send(w[i], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_msb_sel", 32'(m_sel), 7);
    // Continuous stream, always ready
    send_bits(8'hA5, 0, 7);
    chk("a5_valid", 32'(dout_valid), 1);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_sel_wrap", 32'(sel), 0);
    send(1'b0, 1'b0, 1'b0);
    chk("a5_valid_pulse", 32'(dout_valid), 0);
    chk("a5_overrun", 32'(overrun), 0);
    // Same word with idle gaps
    send_bits(8'hA5, 0, 1);
    repeat (3) begin send(1'b1, 1'b0, 1'b0); chk("gap_sel_hold2", 32'(sel), 2); end
    send_bits(8'hA5, 2, 5);
    repeat (3) begin send(1'b0, 1'b0, 1'b0); chk("gap_sel_hold6", 32'(sel), 6); end
    send_bits(8'hA5, 6, 7);
    chk("gap_dout", 32'(dout), 32'hA5);
    send(1'b0, 1'b0, 1'b0);
    // Back-to-back with consumer stalled: second word dropped
    dout_ready = 1'b0;
    send_bits(8'h3C, 0, 7);
    send_bits(8'hF0, 0, 7);
    chk("ovr_dout_held", 32'(dout), 32'h3C);
    chk("ovr_valid", 32'(dout_valid), 1);
    chk("ovr_flag", 32'(overrun), 32'(ref_ovr));
    chk("ovr_flag_set", 32'(overrun), 1);
    dout_ready = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", 32'(overrun), 1);
    // Load-while-pop on the completion edge
    do_reset();
    dout_ready = 1'b0;
    send_bits(8'h3C, 0, 7);
    send_bits(8'hF0, 0, 6);
    chk("lwp_hold", 32'(dout), 32'h3C);
    dout_ready = 1'b1;
    send_bits(8'hF0, 7, 7);
    chk("lwp_dout", 32'(dout), 32'hF0);
    chk("lwp_valid", 32'(dout_valid), 1);
    chk("lwp_no_overrun", 32'(overrun), 0);
    send(1'b0, 1'b0, 1'b0);
    // sync discards partial word
    send_bits(8'hFF, 0, 3);
    send(1'b0, 1'b1, 1'b1);
    chk("sync_sel", 32'(sel), 1);
    send_bits(8'hFF, 1, 7);
    chk("sync_dout", 32'(dout), 32'hFE);
    send(1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 0, 2);
    send(1'b0, 1'b0, 1'b1);
    chk("sync_idle_sel", 32'(sel), 0);
    send_bits(8'h5A, 0, 7);
    chk("sync_idle_dout", 32'(dout), 32'h5A);
    send(1'b0, 1'b0, 1'b0);
    // Asynchronous reset between edges
    send_bits(8'h81, 0, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_valid", 32'(dout_valid), 0);
    #1 rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    send_bits(8'h81, 0, 7);
    chk("arst_81", 32'(dout), 32'h81);
    send(1'b0, 1'b0, 1'b0);
    // MSB-first instance
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      chk("msb_sel", 32'(m_sel), 32'(7 - i));
      m_din = pat[7 - i]; m_vld = 1'b1;
      @(posedge clk); #1;
      m_vld = 1'b0;
    end
    chk("msb_dout", 32'(m_dout), 32'hA5);
    chk("msb_valid", 32'(m_valid_o), 1);
    chk("msb_sel_wrap", 32'(m_sel), 7);
    repeat (2) @(posedge clk);
    #1 chk("sb_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
